// File: rtl/key_press_classifier_if.sv
// Key press classifier bus: debounced key level in, event pulses,
// hold level and event counter out. Clock and reset stay plain ports.
interface key_press_classifier_if;
  logic       Pin_in;
  logic       short_press;
  logic       long_press;
  logic       double_click;
  logic       key_hold;
  logic [7:0] event_cnt;

  modport master (
    output Pin_in,
    input  short_press, long_press, double_click, key_hold, event_cnt
  );

  modport slave (
    input  Pin_in,
    output short_press, long_press, double_click, key_hold, event_cnt
  );
endinterface

// File: rtl/key_press_classifier.sv
// Key press classifier: turns a debounced active-low key level into
// short_press / long_press / double_click pulses, a key_hold level and
// a wrapping 8-bit event counter.
// Optional feature macro: KEY_DCLICK_EN (adds WAIT2/PRESS2 and
// double-click detection). Without it, a release in PRESS1 is reported
// as a short press on the next cycle and double_click stays 0.
module key_press_classifier #(
  parameter int LONG_CNT   = 50_000_000,
  parameter int DCLICK_CNT = 15_000_000
) (
  input  logic                   Sys_clk,
  input  logic                   Sys_reset,
  key_press_classifier_if.slave  kif
);

  // Reject parameter sets that make the timeouts meaningless.
  if (LONG_CNT < 2 || DCLICK_CNT < 2 || DCLICK_CNT >= LONG_CNT) begin : g_param_err
    $error("key_press_classifier: need LONG_CNT >= 2 and 2 <= DCLICK_CNT < LONG_CNT");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    LONG_HOLD = 3'd2
`ifdef KEY_DCLICK_EN
    ,
    WAIT2     = 3'd3,
    PRESS2    = 3'd4
`endif
  } state_t;

  localparam logic [25:0] LONG_TERM = 26'(LONG_CNT - 1);
`ifdef KEY_DCLICK_EN
  localparam logic [25:0] DCLK_TERM = 26'(DCLICK_CNT - 1);
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [25:0] r_cnt;
  logic        r_pin_d;
  logic        r_armed;
  logic        r_short;
  logic        r_long;
  logic        r_hold;
  logic [7:0]  r_event_cnt;
  logic        w_press;
  logic        w_release;
  logic        w_short_nxt;
  logic        w_long_nxt;
  logic        w_dclick_nxt;
  logic        w_evt;

  // r_armed blocks the fake press edge a key held low through reset
  // would otherwise produce against the reset value of r_pin_d.
  assign w_press   = r_armed & r_pin_d & ~kif.Pin_in;
  assign w_release = ~r_pin_d & kif.Pin_in;
  assign w_evt     = w_short_nxt | w_long_nxt | w_dclick_nxt;

  // Next-state and event-trigger decode; edges win over terminal counts.
  always_comb begin
    w_state_nxt  = r_state;
    w_short_nxt  = 1'b0;
    w_long_nxt   = 1'b0;
    w_dclick_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_press) w_state_nxt = PRESS1;
      end
      PRESS1: begin
        if (w_release) begin
`ifdef KEY_DCLICK_EN
          w_state_nxt = WAIT2;
`else
          w_state_nxt = IDLE;
          w_short_nxt = 1'b1;
`endif
        end else if (r_cnt == LONG_TERM) begin
          w_state_nxt = LONG_HOLD;
          w_long_nxt  = 1'b1;
        end
      end
      LONG_HOLD: begin
        if (w_release) w_state_nxt = IDLE;
      end
`ifdef KEY_DCLICK_EN
      WAIT2: begin
        if (w_press) begin
          w_state_nxt = PRESS2;
        end else if (r_cnt == DCLK_TERM) begin
          w_state_nxt = IDLE;
          w_short_nxt = 1'b1;
        end
      end
      PRESS2: begin
        // No timeout here: a long second hold just waits for release.
        if (w_release) begin
          w_state_nxt  = IDLE;
          w_dclick_nxt = 1'b1;
        end
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, per-state cycle counter and input edge history.
  always_ff @(posedge Sys_clk) begin
    if (!Sys_reset) begin
      r_state <= IDLE;
      r_cnt   <= 26'd0;
      r_pin_d <= 1'b1;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (w_state_nxt != r_state) ? 26'd0 : r_cnt + 26'd1;
      r_pin_d <= kif.Pin_in;
      r_armed <= r_armed | kif.Pin_in;
    end
  end

  // Registered event pulses, hold level and event counter.
  always_ff @(posedge Sys_clk) begin
    if (!Sys_reset) begin
      r_short     <= 1'b0;
      r_long      <= 1'b0;
      r_hold      <= 1'b0;
      r_event_cnt <= 8'd0;
    end else begin
      r_short     <= w_short_nxt;
      r_long      <= w_long_nxt;
      r_hold      <= (w_state_nxt == LONG_HOLD);
      r_event_cnt <= r_event_cnt + {7'd0, w_evt};
    end
  end

`ifdef KEY_DCLICK_EN
  logic r_dclick;

  // Double-click pulse register.
  always_ff @(posedge Sys_clk) begin
    if (!Sys_reset) r_dclick <= 1'b0;
    else            r_dclick <= w_dclick_nxt;
  end

  assign kif.double_click = r_dclick;
`else
  assign kif.double_click = 1'b0;
`endif

  assign kif.short_press = r_short;
  assign kif.long_press  = r_long;
  assign kif.key_hold    = r_hold;
  assign kif.event_cnt   = r_event_cnt;

endmodule

// File: tb/tb_key_press_classifier.sv
// Bench for key_press_classifier (LONG_CNT=20, DCLICK_CNT=10): directed
// scenarios followed by random press/release/reset traffic, with every
// cycle compared against a deadline-based reference model.
module tb_key_press_classifier;
  localparam int LONG = 20;
  localparam int DCLK = 10;
`ifdef KEY_DCLICK_EN
  localparam int SHORT_LAT = DCLK + 1;
`else
  localparam int SHORT_LAT = 1;
`endif

  logic Sys_clk = 1'b0;
  logic rstn    = 1'b0;
  key_press_classifier_if kif ();

  key_press_classifier #(.LONG_CNT(LONG), .DCLICK_CNT(DCLK)) dut (
    .Sys_clk  (Sys_clk),
    .Sys_reset(rstn),
    .kif      (kif.slave)
  );

  always #5 Sys_clk = ~Sys_clk;

  int cyc = 0;
  always @(posedge Sys_clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases of the gesture, with absolute-cycle deadlines for timeouts.
  localparam int P_IDLE = 0, P_HELD1 = 1, P_GAP = 2, P_HELD2 = 3, P_LONG = 4;
  int m_phase, m_deadline, m_ecnt;
  bit m_prev, m_armed, m_s, m_l, m_d, m_h;
  bit chk_en = 1'b0;

  int last_s = -1, last_l = -1, last_d = -1;
  int tot_s = 0, tot_l = 0, tot_d = 0;

  task automatic model_step();
    bit press, rel;
    if (!rstn) begin
      m_phase = P_IDLE; m_prev = 1'b1; m_armed = 1'b0; m_ecnt = 0;
      m_s = 0; m_l = 0; m_d = 0; m_h = 0;
      chk_en = 1'b1;
      return;
    end
    press = m_armed && m_prev && !kif.Pin_in;
    rel   = !m_prev && kif.Pin_in;
    m_s = 0; m_l = 0; m_d = 0;
    case (m_phase)
      P_IDLE:  if (press) begin m_phase = P_HELD1; m_deadline = cyc + LONG; end
      P_HELD1: begin
        if (rel) begin
`ifdef KEY_DCLICK_EN
          m_phase = P_GAP; m_deadline = cyc + DCLK;
`else
          m_phase = P_IDLE; m_s = 1;
`endif
        end else if (cyc == m_deadline) begin
          m_phase = P_LONG; m_l = 1;
        end
      end
      P_GAP: begin
        if (press) m_phase = P_HELD2;
        else if (cyc == m_deadline) begin m_phase = P_IDLE; m_s = 1; end
      end
      P_HELD2: if (rel) begin m_phase = P_IDLE; m_d = 1; end
      P_LONG:  if (rel) m_phase = P_IDLE;
      default: m_phase = P_IDLE;
    endcase
    m_h = (m_phase == P_LONG);
    if (m_s || m_l || m_d) m_ecnt = (m_ecnt + 1) % 256;
    m_prev  = kif.Pin_in;
    m_armed = m_armed | kif.Pin_in;
  endtask

  // Per-cycle comparison against the model, then advance the model.
  always @(negedge Sys_clk) begin
    if (chk_en) begin
      chk("short_press",  {31'd0, kif.short_press},  {31'd0, m_s});
      chk("long_press",   {31'd0, kif.long_press},   {31'd0, m_l});
      chk("double_click", {31'd0, kif.double_click}, {31'd0, m_d});
      chk("key_hold",     {31'd0, kif.key_hold},     {31'd0, m_h});
      chk("event_cnt",    {24'd0, kif.event_cnt},    m_ecnt);
      chk("onehot", {31'd0, (2'(kif.short_press) + 2'(kif.long_press) + 2'(kif.double_click)) <= 2'd1}, 1);
      if (kif.short_press  === 1'b1) begin last_s = cyc; tot_s++; end
      if (kif.long_press   === 1'b1) begin last_l = cyc; tot_l++; end
      if (kif.double_click === 1'b1) begin last_d = cyc; tot_d++; end
    end
    model_step();
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic lvl, input int n, output int t0);
    t0 = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge Sys_clk); #1;
      kif.Pin_in = lvl;
      if (i == 0) t0 = cyc;
    end
  endtask

  task automatic do_reset(input logic lvl);
    @(posedge Sys_clk); #1;
    rstn = 1'b0; kif.Pin_in = lvl;
    @(posedge Sys_clk); #1;
    rstn = 1'b1;
  endtask

  int p, r, r1, t, s0, l0, d0;

  initial begin
    kif.Pin_in = 1'b1;
    repeat (3) @(posedge Sys_clk);
    #1 rstn = 1'b1;
    drive(1, 3, t);
    chk("rst_event_cnt", {24'd0, kif.event_cnt}, 0);
    chk("rst_key_hold",  {31'd0, kif.key_hold}, 0);
    chk("rst_events", tot_s + tot_l + tot_d, 0);

    // short press: 5 cycles low, then release
    do_reset(1); drive(1, 5, t);
    s0 = tot_s;
    drive(0, 5, p); drive(1, 30, r);
    chk("short_lat", last_s, r + SHORT_LAT);
    chk("short_num", tot_s - s0, 1);
    chk("short_ecnt", {24'd0, kif.event_cnt}, 1);

    // long press: hold 40 cycles
    l0 = tot_l; s0 = tot_s + tot_d;
    drive(0, 40, p); drive(1, 1, r);
    @(negedge Sys_clk) chk("hold_at_release", {31'd0, kif.key_hold}, 1);
    @(negedge Sys_clk) chk("hold_after_release", {31'd0, kif.key_hold}, 0);
    drive(1, 30, t);
    chk("long_lat", last_l, p + LONG + 1);
    chk("long_num", tot_l - l0, 1);
    chk("long_no_other", tot_s + tot_d - s0, 0);

    // press 4, release 3, press 4, release
    s0 = tot_s; d0 = tot_d;
    drive(0, 4, t); drive(1, 3, t); drive(0, 4, t); drive(1, 30, r);
`ifdef KEY_DCLICK_EN
    chk("dclick_lat", last_d, r + 1);
    chk("dclick_num", tot_d - d0, 1);
    chk("dclick_no_short", tot_s - s0, 0);
`else
    chk("two_short_lat", last_s, r + 1);
    chk("two_short_num", tot_s - s0, 2);
`endif

    // second press on the last cycle of the release window
    s0 = tot_s; d0 = tot_d;
    drive(0, 3, t); drive(1, DCLK, r1); drive(0, 3, t); drive(1, 30, r);
`ifdef KEY_DCLICK_EN
    chk("dclick_edge_lat", last_d, r + 1);
    chk("dclick_edge_num", tot_d - d0, 1);
    chk("dclick_edge_no_short", tot_s - s0, 0);
`else
    chk("edge_two_short", tot_s - s0, 2);
`endif

    // reset during a held press, key still held after reset
    do_reset(1);
    s0 = tot_s + tot_l + tot_d;
    drive(0, 10, p); do_reset(0); drive(0, 40, t); drive(1, 30, t);
    chk("rst_mid_events", tot_s + tot_l + tot_d - s0, 0);
    chk("rst_mid_ecnt", {24'd0, kif.event_cnt}, 0);

    // event counter wrap
    do_reset(1);
    s0 = tot_s;
    for (int i = 0; i < 255; i++) begin
      drive(0, 2, t); drive(1, SHORT_LAT + 3, t);
    end
    chk("ecnt_255", {24'd0, kif.event_cnt}, 255);
    drive(0, 2, t); drive(1, SHORT_LAT + 3, t);
    chk("ecnt_wrap", {24'd0, kif.event_cnt}, 0);
    chk("wrap_num", tot_s - s0, 256);

    // random traffic, including glitches, boundary holds and resets
    for (int i = 0; i < 120; i++) begin
      drive(0, $urandom_range(1, LONG + 3), t);
      if ($urandom_range(0, 9) == 0) do_reset($urandom_range(0, 1) == 1);
      drive(1, $urandom_range(1, DCLK + 3), t);
      if ($urandom_range(0, 15) == 0) do_reset(1);
    end
    drive(1, 40, t);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
